// File: rtl/traffic_pkg.sv
// Shared lamp encodings, decoded lamp-state type and lightout bus helpers.
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  // Widest bus the slice helper accepts; narrower buses are zero-extended.
  localparam int MAX_ROADS = 16;

  typedef enum logic [1:0] {L_RED, L_YEL, L_GRN, L_BAD} lamp_t;

  function automatic logic [2:0] road_bits(input logic [3*MAX_ROADS-1:0] bus,
                                           input int unsigned k);
    logic [3*MAX_ROADS-1:0] sh;
    sh = bus >> (3 * k);
    return sh[2:0];
  endfunction

  function automatic lamp_t decode_lamp(input logic [2:0] code);
    case (code)
      LIGHT_RED: return L_RED;
      LIGHT_YEL: return L_YEL;
      LIGHT_GRN: return L_GRN;
      default:   return L_BAD;
    endcase
  endfunction

endpackage

// File: rtl/tl_road_checker.sv
// Per-road lamp decode, previous legal state, run-length counter and
// transition/timing error pulses for the current sample.
module tl_road_checker
  import traffic_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int MIN_GREEN  = 3,
  parameter int MIN_YELLOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] code,
  input  logic       sync,
  output lamp_t      lamp,
  output logic       seq_err,
  output logic       tim_err,
  output logic       yel_to_red
);

  localparam logic [31:0] MING = MIN_GREEN;
  localparam logic [31:0] MINY = MIN_YELLOW;

  lamp_t            prev;
  logic [CNT_W-1:0] run;

  assign lamp = decode_lamp(code);

  always_comb begin
    seq_err    = 1'b0;
    tim_err    = 1'b0;
    yel_to_red = 1'b0;
    if (sync && lamp != L_BAD) begin
      if ((prev == L_RED && lamp == L_YEL) ||
          (prev == L_GRN && lamp == L_RED) ||
          (prev == L_YEL && lamp == L_GRN))
        seq_err = 1'b1;
      if (prev == L_GRN && lamp == L_YEL && 32'(run) < MING)
        tim_err = 1'b1;
      if (prev == L_YEL && lamp == L_RED) begin
        yel_to_red = 1'b1;
        if (32'(run) < MINY)
          tim_err = 1'b1;
      end
    end
  end

  // Stage p0 -> p1: illegal codes leave the history untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= L_RED;
      run  <= '0;
    end else if (lamp != L_BAD) begin
      prev <= lamp;
      if (sync && lamp == prev)
        run <= (&run) ? run : run + 1'b1;
      else
        run <= CNT_W'(1);
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker on the controller's lightout bus: active road, phase length,
// rotation count and sticky protocol error flags, all registered.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int NUM_ROADS  = 4,
  parameter int MIN_GREEN  = 3,
  parameter int MIN_YELLOW = 1,
  parameter int CNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3*NUM_ROADS-1:0] lightout,
  input  logic                   clr_err,
  output logic [1:0]             active_road,
  output logic                   active_valid,
  output logic [CNT_W-1:0]       phase_cnt,
  output logic [CNT_W-1:0]       rotations,
  output logic                   err_illegal,
  output logic                   err_conflict,
  output logic                   err_sequence,
  output logic                   err_timing
);

  logic [3*MAX_ROADS-1:0] bus;
  lamp_t                  lamp [NUM_ROADS];
  logic [NUM_ROADS-1:0]   seq_v, tim_v, ytr_v;
  logic [3*NUM_ROADS-1:0] lightout_p1;
  logic                   sync;
  int                     nonred_cnt;
  logic [1:0]             sel_road;
  logic                   any_bad;

  always_comb begin
    bus                    = '0;
    bus[3*NUM_ROADS-1:0]   = lightout;
  end

  for (genvar k = 0; k < NUM_ROADS; k++) begin : g_road
    tl_road_checker #(
      .CNT_W      (CNT_W),
      .MIN_GREEN  (MIN_GREEN),
      .MIN_YELLOW (MIN_YELLOW)
    ) u_chk (
      .clk        (clk),
      .rst        (rst),
      .code       (road_bits(bus, k)),
      .sync       (sync),
      .lamp       (lamp[k]),
      .seq_err    (seq_v[k]),
      .tim_err    (tim_v[k]),
      .yel_to_red (ytr_v[k])
    );
  end

  always_comb begin
    nonred_cnt = 0;
    sel_road   = '0;
    any_bad    = 1'b0;
    for (int k = 0; k < NUM_ROADS; k++) begin
      if (lamp[k] == L_BAD)
        any_bad = 1'b1;
      else if (lamp[k] != L_RED) begin
        nonred_cnt = nonred_cnt + 1;
        sel_road   = 2'(k);
      end
    end
  end

  // Stage p0 -> p1: aggregate road results into registered status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync         <= 1'b0;
      lightout_p1  <= '0;
      active_road  <= '0;
      active_valid <= 1'b0;
      phase_cnt    <= '0;
      rotations    <= '0;
      err_illegal  <= 1'b0;
      err_conflict <= 1'b0;
      err_sequence <= 1'b0;
      err_timing   <= 1'b0;
    end else begin
      sync        <= 1'b1;
      lightout_p1 <= lightout;
      if (!sync || lightout != lightout_p1)
        phase_cnt <= CNT_W'(1);
      else
        phase_cnt <= (&phase_cnt) ? phase_cnt : phase_cnt + 1'b1;
      if (ytr_v[NUM_ROADS-1])
        rotations <= rotations + 1'b1;
      active_valid <= (nonred_cnt == 1);
      if (nonred_cnt == 1)
        active_road <= sel_road;
      err_illegal  <= (err_illegal  & ~clr_err) | any_bad;
      err_conflict <= (err_conflict & ~clr_err) | (nonred_cnt > 1);
      err_sequence <= (err_sequence & ~clr_err) | (|seq_v);
      err_timing   <= (err_timing   & ~clr_err) | (|tim_v);
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench: two monitors (CNT_W=8 and CNT_W=2) share stimulus and are
// checked against a lamp-rule reference model.
module tb_traffic_light_monitor;

  localparam int NR   = 4;
  localparam int MING = 3;
  localparam int MINY = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_err = 1'b0;
  logic [11:0] lightout = 12'h924;

  logic [1:0] a_ar, b_ar;
  logic       a_av, b_av;
  logic [7:0] a_ph, a_rot;
  logic [1:0] b_ph, b_rot;
  logic       a_ill, a_conf, a_seq, a_tim;
  logic       b_ill, b_conf, b_seq, b_tim;

  traffic_light_monitor #(.NUM_ROADS(NR), .MIN_GREEN(MING), .MIN_YELLOW(MINY), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .lightout(lightout), .clr_err(clr_err),
    .active_road(a_ar), .active_valid(a_av), .phase_cnt(a_ph), .rotations(a_rot),
    .err_illegal(a_ill), .err_conflict(a_conf), .err_sequence(a_seq), .err_timing(a_tim));

  traffic_light_monitor #(.NUM_ROADS(NR), .MIN_GREEN(MING), .MIN_YELLOW(MINY), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .lightout(lightout), .clr_err(clr_err),
    .active_road(b_ar), .active_valid(b_av), .phase_cnt(b_ph), .rotations(b_rot),
    .err_illegal(b_ill), .err_conflict(b_conf), .err_sequence(b_seq), .err_timing(b_tim));

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int ar;
    bit av;
    int ph;
    int rot;
    bit ill, conf, seq, tim;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model state: lamp order R=0, G=1, Y=2 so legal moves are +1 mod 3
  int          ps [NR];
  int          run[NR];
  bit          synced;
  logic [11:0] plo;
  int          phase, rot, m_ar;
  bit          m_av, f_ill, f_conf, f_seq, f_tim;

  function automatic void model(input logic [11:0] lo, input bit clr, input bit r);
    exp_t x;
    int nonred, idx, s;
    bit n_ill, n_seq, n_tim;
    if (r) begin
      for (int k = 0; k < NR; k++) begin ps[k] = 0; run[k] = 0; end
      synced = 0; plo = '0; phase = 0; rot = 0; m_ar = 0; m_av = 0;
      f_ill = 0; f_conf = 0; f_seq = 0; f_tim = 0;
    end else begin
      nonred = 0; idx = 0; n_ill = 0; n_seq = 0; n_tim = 0;
      for (int k = 0; k < NR; k++) begin
        case (lo[3*k +: 3])
          3'b100:  s = 0;
          3'b001:  s = 1;
          3'b010:  s = 2;
          default: s = -1;
        endcase
        if (s < 0) n_ill = 1;
        else begin
          if (s != 0) begin nonred++; idx = k; end
          if (synced) begin
            if (s != ps[k] && s != (ps[k] + 1) % 3) n_seq = 1;
            if (ps[k] == 1 && s == 2 && run[k] < MING) n_tim = 1;
            if (ps[k] == 2 && s == 0 && run[k] < MINY) n_tim = 1;
            if (k == NR - 1 && ps[k] == 2 && s == 0) rot++;
            run[k] = (s == ps[k]) ? run[k] + 1 : 1;
          end else run[k] = 1;
          ps[k] = s;
        end
      end
      m_av = (nonred == 1);
      if (m_av) m_ar = idx;
      phase = (!synced || lo != plo) ? 1 : phase + 1;
      plo = lo;
      synced = 1;
      f_ill  = (f_ill  && !clr) || n_ill;
      f_conf = (f_conf && !clr) || (nonred > 1);
      f_seq  = (f_seq  && !clr) || n_seq;
      f_tim  = (f_tim  && !clr) || n_tim;
    end
    x.cyc = cycle; x.ar = m_ar; x.av = m_av; x.ph = phase; x.rot = rot;
    x.ill = f_ill; x.conf = f_conf; x.seq = f_seq; x.tim = f_tim;
    sbq.push_back(x);
  endfunction

  task automatic step(input logic [11:0] lo, input bit clr, input bit r);
    @(negedge clk);
    cycle++;
    rst = r; lightout = lo; clr_err = clr;
    model(lo, clr, r);
  endtask

  function automatic logic [11:0] vec(input int k, input logic [2:0] c);
    logic [11:0] v;
    v = 12'h924;
    v[3*k +: 3] = c;
    return v;
  endfunction

  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", nm, cyc, act, expv);
    end
  endtask

  exp_t e;
  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("a.active_road",  e.cyc, 32'(a_ar),  e.ar);
      chk("a.active_valid", e.cyc, 32'(a_av),  32'(e.av));
      chk("a.phase_cnt",    e.cyc, 32'(a_ph),  (e.ph > 255) ? 255 : e.ph);
      chk("a.rotations",    e.cyc, 32'(a_rot), e.rot % 256);
      chk("a.err_illegal",  e.cyc, 32'(a_ill), 32'(e.ill));
      chk("a.err_conflict", e.cyc, 32'(a_conf), 32'(e.conf));
      chk("a.err_sequence", e.cyc, 32'(a_seq), 32'(e.seq));
      chk("a.err_timing",   e.cyc, 32'(a_tim), 32'(e.tim));
      chk("b.active_road",  e.cyc, 32'(b_ar),  e.ar);
      chk("b.active_valid", e.cyc, 32'(b_av),  32'(e.av));
      chk("b.phase_cnt",    e.cyc, 32'(b_ph),  (e.ph > 3) ? 3 : e.ph);
      chk("b.rotations",    e.cyc, 32'(b_rot), e.rot % 4);
      chk("b.err_illegal",  e.cyc, 32'(b_ill), 32'(e.ill));
      chk("b.err_conflict", e.cyc, 32'(b_conf), 32'(e.conf));
      chk("b.err_sequence", e.cyc, 32'(b_seq), 32'(e.seq));
      chk("b.err_timing",   e.cyc, 32'(b_tim), 32'(e.tim));
    end
  end

  initial begin
    int gr, gst, gleft;
    logic [11:0] lo;
    bit r, clr;

    step(12'h924, 0, 1); step(12'h924, 0, 1);

    // Legal cycle on road 0
    repeat (2) step(12'h924, 0, 0);
    repeat (4) step(12'h921, 0, 0);
    repeat (2) step(12'h922, 0, 0);
    step(12'h924, 0, 0);

    // Short green
    step(12'h924, 0, 1);
    step(12'h924, 0, 0);
    repeat (2) step(12'h921, 0, 0);
    step(12'h922, 0, 0);

    // Conflict then illegal
    step(12'h924, 0, 1);
    step(12'h889, 0, 0);
    step(12'h926, 0, 0);

    // Sequence error then clear
    step(12'h924, 0, 1);
    step(12'h924, 0, 0);
    step(12'h922, 0, 0);
    step(12'h924, 1, 0);
    step(12'h924, 0, 0);

    // Four full rotations, then a long all-red hold
    step(12'h924, 0, 1);
    step(12'h924, 0, 0);
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < NR; k++) begin
        repeat (3) step(vec(k, 3'b001), 0, 0);
        step(vec(k, 3'b010), 0, 0);
        step(12'h924, 0, 0);
      end
    repeat (5) step(12'h924, 0, 0);

    // Reset in the middle of a green, release on yellow
    step(12'h924, 0, 0);
    repeat (2) step(12'h921, 0, 0);
    repeat (2) step(12'h921, 0, 1);
    repeat (2) step(12'h922, 0, 0);
    step(12'h924, 0, 0);

    // Randomised legal rotation with injected garbage, clears and resets
    gr = 0; gst = 0; gleft = 1;
    for (int i = 0; i < 800; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      clr = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0)
        lo = 12'($urandom);
      else begin
        case (gst)
          1:       lo = vec(gr, 3'b001);
          2:       lo = vec(gr, 3'b010);
          default: lo = 12'h924;
        endcase
        gleft--;
        if (gleft <= 0) begin
          case (gst)
            0: begin gst = 1; gleft = $urandom_range(1, 6); end
            1: begin gst = 2; gleft = $urandom_range(1, 3); end
            default: begin gst = 0; gleft = $urandom_range(1, 3); gr = (gr + 1) % NR; end
          endcase
        end
      end
      step(lo, clr, r);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
